// File: rtl/sram_pkg.sv
// Shared types for the asynchronous SRAM access controller.
// Imported by sram_access_ctrl for its FSM state encoding.
package sram_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } sram_state_e;

endpackage

// File: rtl/sram_access_ctrl.sv
// Single-request controller for an asynchronous SRAM: IDLE -> ACCESS (WAIT_CYC cycles) -> DONE.
// All SRAM-side outputs come straight from flops; the tristate buffer lives at the chip top.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [DATA_W-1:0]   sram_dq_in
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned CntW = $clog2(WAIT_CYC + 1);

  if (DATA_W % 8 != 0) begin : gen_bad_data_w
    $error("sram_access_ctrl: DATA_W must be a multiple of 8");
  end
  if (WAIT_CYC < 1) begin : gen_bad_wait_cyc
    $error("sram_access_ctrl: WAIT_CYC must be at least 1");
  end

  sram_state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              cap_we_q, cap_we_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
  logic [BeW-1:0]    cap_be_q, cap_be_d;

  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [BeW-1:0]    be_n_q, be_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic accept;
  logic be_zero_wr;
  logic last_access;

  assign accept      = req_valid && (state_q == StIdle);
  assign be_zero_wr  = req_we && (req_be == '0);
  assign last_access = (state_q == StAccess) && (cnt_q == CntW'(1));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = be_zero_wr ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request handshake and response outputs.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StDone);
  end

  // Request capture, wait counter and read-data capture.
  always_comb begin
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_be_d    = cap_be_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;

    if (accept) begin
      cap_we_d    = req_we;
      cap_addr_d  = req_addr;
      cap_wdata_d = req_wdata;
      cap_be_d    = req_be;
      cnt_d       = be_zero_wr ? '0 : CntW'(WAIT_CYC);
    end else if (state_q == StAccess) begin
      cnt_d = cnt_q - CntW'(1);
    end

    if (last_access && !cap_we_q) begin
      rdata_d = sram_dq_in;
    end
  end

  // SRAM pin values are decoded from the next state so the flops present them in that state.
  always_comb begin
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    be_n_d   = '1;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    unique case (state_d)
      StAccess: begin
        ce_n_d = 1'b0;
        addr_d = cap_addr_d;
        if (cap_we_d) begin
          we_n_d   = 1'b0;
          be_n_d   = ~cap_be_d;
          dq_oe_d  = 1'b1;
          dq_out_d = cap_wdata_d;
        end else begin
          oe_n_d = 1'b0;
          be_n_d = '0;
        end
      end
      // Keep driving write data one cycle past the rising edge of we_n.
      StDone:  dq_oe_d = dq_oe_q;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_be_q    <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_be_q    <= cap_be_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      rdata_q     <= rdata_d;
    end
  end

  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign rsp_rdata   = rdata_q;

  // Bus-contention guards.
  a_no_oe_we_overlap : assert property (@(posedge Clk) disable iff (Reset)
    !(!sram_oe_n && !sram_we_n));
  a_no_drive_on_read : assert property (@(posedge Clk) disable iff (Reset)
    !(sram_dq_oe && !sram_oe_n));

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default build (16b, WAIT_CYC=2) plus a 32b, WAIT_CYC=1 build.
module tb_sram_access_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset;

  // Instance A: DATA_W=16, ADDR_W=20, WAIT_CYC=2.
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [19:0] a_req_addr;
  logic [15:0] a_req_wdata;
  logic [1:0]  a_req_be;
  logic        a_rsp_valid;
  logic [15:0] a_rsp_rdata;
  logic        a_ce_n, a_oe_n, a_we_n;
  logic [1:0]  a_be_n;
  logic [19:0] a_addr;
  logic [15:0] a_dq_out, a_dq_in;
  logic        a_dq_oe;

  // Instance B: DATA_W=32, ADDR_W=20, WAIT_CYC=1.
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [19:0] b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_rdata;
  logic        b_ce_n, b_oe_n, b_we_n;
  logic [3:0]  b_be_n;
  logic [19:0] b_addr;
  logic [31:0] b_dq_out, b_dq_in;
  logic        b_dq_oe;

  sram_access_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYC(2)) u_dut_a (
    .Clk(Clk), .Reset(Reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_be_n(a_be_n),
    .sram_addr(a_addr), .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_dq_in(a_dq_in)
  );

  sram_access_ctrl #(.DATA_W(32), .ADDR_W(20), .WAIT_CYC(1)) u_dut_b (
    .Clk(Clk), .Reset(Reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n),
    .sram_addr(b_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int viol   = 0;
  int cyc    = 0;
  int a_rsp_cyc[$];
  int a_acc_cyc[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Mid-cycle monitor: handshake/response timing and strobe-rule violations.
  always @(negedge Clk) begin
    if (a_rsp_valid) a_rsp_cyc.push_back(cyc);
    if (a_req_valid && a_req_ready && !Reset) a_acc_cyc.push_back(cyc);
    if (!a_oe_n && !a_we_n) viol++;
    if (a_dq_oe && !a_oe_n) viol++;
    if (!b_oe_n && !b_we_n) viol++;
    if (b_dq_oe && !b_oe_n) viol++;
  end

  // Issue one request on A; lat = edges from accept to the edge that sees rsp_valid.
  task automatic a_run(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, output int lat, output int n_ce, output int n_oe,
                       output int n_we, output logic [1:0] be_n_seen,
                       output logic [19:0] addr_seen);
    int guard;
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be; a_req_valid = 1'b1;
    guard = 0;
    while (!a_req_ready && guard < 20) begin tick(); guard++; end
    tick();
    a_req_valid = 1'b0;
    lat = 1; n_ce = 0; n_oe = 0; n_we = 0; be_n_seen = 2'b11; addr_seen = '0;
    while (!a_rsp_valid && lat < 20) begin
      if (!a_ce_n) begin n_ce++; addr_seen = a_addr; end
      if (!a_oe_n) n_oe++;
      if (!a_we_n) begin n_we++; be_n_seen = a_be_n; end
      tick();
      lat++;
    end
  endtask

  task automatic b_run(input logic we, input logic [31:0] wdata, input logic [3:0] be,
                       output int lat, output int n_oe, output int n_we,
                       output logic [3:0] be_n_seen);
    int guard;
    b_req_we = we; b_req_addr = 20'h00009; b_req_wdata = wdata; b_req_be = be;
    b_req_valid = 1'b1;
    guard = 0;
    while (!b_req_ready && guard < 20) begin tick(); guard++; end
    tick();
    b_req_valid = 1'b0;
    lat = 1; n_oe = 0; n_we = 0; be_n_seen = 4'hF;
    while (!b_rsp_valid && lat < 20) begin
      if (!b_oe_n) n_oe++;
      if (!b_we_n) begin n_we++; be_n_seen = b_be_n; end
      tick();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int lat, n_ce, n_oe, n_we;
    logic [1:0]  be_n_seen;
    logic [3:0]  b_be_n_seen;
    logic [19:0] addr_seen;
    int guard;

    Reset = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    a_dq_in = '0; b_dq_in = '0;
    tick(); tick(); tick();
    Reset = 1'b0;

    check_val("rst_ready", a_req_ready, 1);
    check_val("rst_rsp_valid", a_rsp_valid, 0);
    check_val("rst_rdata", a_rsp_rdata, 0);
    check_val("rst_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
    check_val("rst_be_n", a_be_n, 2'b11);
    check_val("rst_addr", a_addr, 0);
    check_val("rst_dq", {a_dq_oe, a_dq_out}, 0);
    check_val("b_rst_be_n", b_be_n, 4'hF);

    // Read at WAIT_CYC=2.
    a_dq_in = 16'hBEEF;
    a_run(1'b0, 20'h00012, 16'h0000, 2'b11, lat, n_ce, n_oe, n_we, be_n_seen, addr_seen);
    check_val("rd_latency", lat, 3);
    check_val("rd_oe_cycles", n_oe, 2);
    check_val("rd_we_cycles", n_we, 0);
    check_val("rd_addr", addr_seen, 20'h00012);
    check_val("rd_rdata", a_rsp_rdata, 16'hBEEF);
    check_val("rd_done_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
    a_dq_in = 16'h1234;
    tick();
    check_val("rd_pulse_one_cycle", a_rsp_valid, 0);
    check_val("rd_back_to_idle", a_req_ready, 1);

    // Upper-byte write.
    a_run(1'b1, 20'h00034, 16'hA55A, 2'b10, lat, n_ce, n_oe, n_we, be_n_seen, addr_seen);
    check_val("wr_latency", lat, 3);
    check_val("wr_we_cycles", n_we, 2);
    check_val("wr_oe_cycles", n_oe, 0);
    check_val("wr_be_n", be_n_seen, 2'b01);
    check_val("wr_done_dq_hold", {a_dq_oe, a_dq_out}, {1'b1, 16'hA55A});
    check_val("wr_done_we_n", a_we_n, 1);
    check_val("wr_rdata_kept", a_rsp_rdata, 16'hBEEF);
    tick();
    check_val("wr_idle_dq_oe", a_dq_oe, 0);

    // Zero byte-enable write is a no-op.
    a_run(1'b1, 20'h00056, 16'hFFFF, 2'b00, lat, n_ce, n_oe, n_we, be_n_seen, addr_seen);
    check_val("nobe_latency", lat, 1);
    check_val("nobe_ce_cycles", n_ce, 0);
    check_val("nobe_done_strobes", {a_ce_n, a_we_n, a_dq_oe}, 3'b110);
    tick();

    // Back-to-back: req_valid held across four alternating requests.
    a_dq_in = 16'h5A5A;
    a_rsp_cyc.delete();
    a_acc_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      a_req_we = i[0]; a_req_addr = 20'h00100 + 20'(i); a_req_wdata = 16'(i); a_req_be = 2'b11;
      a_req_valid = 1'b1;
      guard = 0;
      while (!a_req_ready && guard < 20) begin tick(); guard++; end
      tick();
    end
    a_req_valid = 1'b0;
    repeat (8) tick();
    check_val("b2b_rsp_count", a_rsp_cyc.size(), 4);
    check_val("b2b_acc_count", a_acc_cyc.size(), 4);
    if (a_rsp_cyc.size() == 4 && a_acc_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        check_val("b2b_rsp_spacing", a_rsp_cyc[i] - a_rsp_cyc[i-1], 4);
        check_val("b2b_acc_spacing", a_acc_cyc[i] - a_acc_cyc[i-1], 4);
      end
    end
    check_val("b2b_rdata", a_rsp_rdata, 16'h5A5A);

    // Reset during the first ACCESS cycle of a read.
    a_rsp_cyc.delete();
    a_req_we = 1'b0; a_req_addr = 20'h00078; a_req_be = 2'b11; a_req_valid = 1'b1;
    guard = 0;
    while (!a_req_ready && guard < 20) begin tick(); guard++; end
    tick();
    a_req_valid = 1'b0;
    check_val("mid_in_access", a_ce_n, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("mid_strobes", {a_ce_n, a_oe_n, a_we_n}, 3'b111);
    check_val("mid_be_n", a_be_n, 2'b11);
    check_val("mid_ready", a_req_ready, 1);
    check_val("mid_rsp_valid", a_rsp_valid, 0);
    check_val("mid_rdata", a_rsp_rdata, 0);
    repeat (5) tick();
    check_val("mid_no_rsp", a_rsp_cyc.size(), 0);

    // 32-bit, WAIT_CYC=1 instance.
    b_run(1'b1, 32'hCAFEF00D, 4'b0101, lat, n_oe, n_we, b_be_n_seen);
    check_val("b_wr_latency", lat, 2);
    check_val("b_wr_we_cycles", n_we, 1);
    check_val("b_wr_be_n", b_be_n_seen, 4'b1010);
    check_val("b_wr_done_dq", {b_dq_oe, b_dq_out}, {1'b1, 32'hCAFEF00D});
    tick();
    b_dq_in = 32'h89ABCDEF;
    b_run(1'b0, 32'h0, 4'hF, lat, n_oe, n_we, b_be_n_seen);
    check_val("b_rd_latency", lat, 2);
    check_val("b_rd_oe_cycles", n_oe, 1);
    check_val("b_rd_rdata", b_rsp_rdata, 32'h89ABCDEF);
    tick();

    check_val("strobe_rules", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
